wb_master_arbiter: RTL and testbench

//  Two-master round-robin arbiter in front of the single Wishbone master port of bus_top.

---
 rtl/wb_master_arbiter.sv | 173 +++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: round-robin or fixed priority in front of one bus port,
// with grant hold until ack/abort, per-grant watchdog and a one-cycle error response.
module wb_master_arbiter #(
    parameter int unsigned RR_EN     = 1,
    parameter int unsigned TO_CYCLES = 255,
    parameter int unsigned TO_WIDTH  = 8,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam bit                  RR_ON   = (RR_EN != 32'd0);
    localparam bit                  TO_ON   = (TO_CYCLES != 32'd0);
    // Only meaningful when TO_ON; the wrap for TO_CYCLES=0 is never compared.
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TO_CYCLES - 32'd1);
    localparam logic [TO_WIDTH-1:0] WD_MAX  = {TO_WIDTH{1'b1}};

    state_t              state_r;
    state_t              state_s;
    logic                last_grant_r;   // 0: m0 was granted last, 1: m1
    logic                last_grant_s;
    logic [TO_WIDTH-1:0] wd_r;
    logic [TO_WIDTH-1:0] wd_s;
    logic                pick_m1_s;
    logic                cur_req_s;

    // Request of the master owning the current grant.
    assign cur_req_s = (state_r == ST_GNT1) ? m1_req_i : m0_req_i;

    // Arbitration winner among the current requesters.
    always_comb begin
        pick_m1_s = 1'b0;
        if (m0_req_i && m1_req_i) begin
            pick_m1_s = RR_ON ? ~last_grant_r : 1'b0;
        end else begin
            pick_m1_s = m1_req_i;
        end
    end

    // State register, last-grant memory and watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            wd_r         <= {TO_WIDTH{1'b0}};
        end else begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
            wd_r         <= wd_s;
        end
    end

    // Next-state logic; the watchdog clears whenever the grant is not being held.
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        wd_s         = {TO_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    state_s      = pick_m1_s ? ST_GNT1 : ST_GNT0;
                    last_grant_s = pick_m1_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GNT0, ST_GNT1: begin
                // Ack beats both abort and timeout in the same cycle.
                if (wb_ack_i) begin
                    state_s = ST_IDLE;
                end else if (!cur_req_s) begin
                    state_s = ST_IDLE;
                end else if (TO_ON && (wd_r == TO_LAST)) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = state_r;
                    wd_s    = (wd_r == WD_MAX) ? wd_r : (wd_r + TO_WIDTH'(1));
                end
            end
            ST_ERR: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Bus mux and master responses; everything stays 0 outside the owning state.
    always_comb begin
        wb_addr_o = 32'h0000_0000;
        wb_data_o = 32'h0000_0000;
        wb_we_o   = 1'b0;
        wb_sel_o  = 4'h0;
        m0_data_o = 32'h0000_0000;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_data_o = 32'h0000_0000;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        grant_o   = 2'b00;
        case (state_r)
            ST_GNT0: begin
                wb_addr_o = m0_addr_i;
                wb_data_o = m0_data_i;
                wb_we_o   = m0_we_i;
                wb_sel_o  = m0_sel_i;
                m0_data_o = wb_data_i;
                m0_ack_o  = wb_ack_i;
                grant_o   = 2'b01;
            end
            ST_GNT1: begin
                wb_addr_o = m1_addr_i;
                wb_data_o = m1_data_i;
                wb_we_o   = m1_we_i;
                wb_sel_o  = m1_sel_i;
                m1_data_o = wb_data_i;
                m1_ack_o  = wb_ack_i;
                grant_o   = 2'b10;
            end
            ST_ERR: begin
                // last_grant still names the master whose access timed out.
                if (last_grant_r) begin
                    m1_err_o  = 1'b1;
                    m1_data_o = ERR_DATA;
                    grant_o   = 2'b10;
                end else begin
                    m0_err_o  = 1'b1;
                    m0_data_o = ERR_DATA;
                    grant_o   = 2'b01;
                end
            end
            ST_IDLE: begin
                grant_o = 2'b00;
            end
            default: begin
                grant_o = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench: instance a (round-robin, 4-cycle watchdog) and instance b (fixed priority)
// share all inputs; b is only checked in the arbitration scenario.
module tb_wb_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we, wb_ack;
    logic [31:0] m0_addr, m0_data, m1_addr, m1_data, wb_rdata;
    logic [3:0]  m0_sel, m1_sel;

    logic [31:0] a_m0_data, a_m1_data, a_wb_addr, a_wb_data;
    logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_wb_we;
    logic [3:0]  a_wb_sel;
    logic [1:0]  a_grant;
    logic [31:0] b_m0_data, b_m1_data, b_wb_addr, b_wb_data;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_wb_we;
    logic [3:0]  b_wb_sel;
    logic [1:0]  b_grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_master_arbiter #(.RR_EN(1), .TO_CYCLES(4), .TO_WIDTH(8), .ERR_DATA(32'hDEADBEEF)) dut_a (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_data_o(a_m0_data), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_data_o(a_m1_data), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
        .wb_addr_o(a_wb_addr), .wb_data_o(a_wb_data), .wb_we_o(a_wb_we), .wb_sel_o(a_wb_sel),
        .wb_data_i(wb_rdata), .wb_ack_i(wb_ack), .grant_o(a_grant)
    );

    wb_master_arbiter #(.RR_EN(0)) dut_b (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_data_o(b_m0_data), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_data_o(b_m1_data), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
        .wb_addr_o(b_wb_addr), .wb_data_o(b_wb_data), .wb_we_o(b_wb_we), .wb_sel_o(b_wb_sel),
        .wb_data_i(wb_rdata), .wb_ack_i(wb_ack), .grant_o(b_grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_data = 32'h0; m0_sel = 4'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_data = 32'h0; m1_sel = 4'h0;
        wb_ack = 1'b0; wb_rdata = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        m0_req = 1'b1; m0_addr = 32'hA000_0010; m0_we = 1'b1; m0_sel = 4'hF; m0_data = 32'h1111_2222;
        tick();
        tick();
        #1;
        checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=%b", a_grant, 2'b00); end
        checks++; if (a_wb_addr !== 32'h0 || a_wb_sel !== 4'h0 || a_wb_we !== 1'b0 || a_wb_data !== 32'h0) begin
            errors++; $display("FAIL reset_wb got addr=%h sel=%h we=%b data=%h exp all 0", a_wb_addr, a_wb_sel, a_wb_we, a_wb_data); end
        checks++; if (a_m0_ack !== 1'b0 || a_m0_err !== 1'b0 || a_m0_data !== 32'h0) begin
            errors++; $display("FAIL reset_m0 got ack=%b err=%b data=%h exp 0", a_m0_ack, a_m0_err, a_m0_data); end
        rst = 1'b0;
        tick();
        #1;
        checks++; if (a_grant !== 2'b01) begin errors++; $display("FAIL reset_first_grant got=%b exp=%b", a_grant, 2'b01); end
        checks++; if (a_wb_addr !== 32'hA000_0010) begin errors++; $display("FAIL reset_first_addr got=%h exp=%h", a_wb_addr, 32'hA000_0010); end
    endtask

    task automatic test_ack();
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h0000_4000; m0_data = 32'hCAFE_0001; m0_we = 1'b1; m0_sel = 4'h3;
        tick();
        #1;
        checks++; if (a_grant !== 2'b01) begin errors++; $display("FAIL ack_grant got=%b exp=%b", a_grant, 2'b01); end
        checks++; if (a_wb_data !== 32'hCAFE_0001 || a_wb_we !== 1'b1 || a_wb_sel !== 4'h3) begin
            errors++; $display("FAIL ack_mux got data=%h we=%b sel=%h exp cafe0001/1/3", a_wb_data, a_wb_we, a_wb_sel); end
        checks++; if (a_m0_ack !== 1'b0) begin errors++; $display("FAIL ack_early got=%b exp=0", a_m0_ack); end
        tick();
        tick();
        wb_ack = 1'b1; wb_rdata = 32'h1234_5678;
        #1;
        checks++; if (a_m0_ack !== 1'b1) begin errors++; $display("FAIL ack_pulse got=%b exp=1", a_m0_ack); end
        checks++; if (a_m0_data !== 32'h1234_5678) begin errors++; $display("FAIL ack_rdata got=%h exp=%h", a_m0_data, 32'h1234_5678); end
        checks++; if (a_m1_data !== 32'h0 || a_m1_ack !== 1'b0) begin errors++; $display("FAIL ack_other got data=%h ack=%b exp 0", a_m1_data, a_m1_ack); end
        tick();
        wb_ack = 1'b0; m0_req = 1'b0;
        #1;
        checks++; if (a_grant !== 2'b00 || a_wb_sel !== 4'h0) begin errors++; $display("FAIL ack_idle got grant=%b sel=%h exp 00/0", a_grant, a_wb_sel); end
        checks++; if (a_m0_ack !== 1'b0 || a_m0_data !== 32'h0) begin errors++; $display("FAIL ack_after got ack=%b data=%h exp 0", a_m0_ack, a_m0_data); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g;
        logic [31:0] exp_addr;
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h0000_0A00; m0_sel = 4'hF;
        m1_req = 1'b1; m1_addr = 32'h0000_0B00; m1_sel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            exp_g    = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (k % 2 == 0) ? 32'h0000_0A00 : 32'h0000_0B00;
            tick();
            #1;
            checks++; if (a_grant !== exp_g || a_wb_addr !== exp_addr) begin
                errors++; $display("FAIL rr_grant%0d got=%b/%h exp=%b/%h", k, a_grant, a_wb_addr, exp_g, exp_addr); end
            checks++; if (b_grant !== 2'b01) begin errors++; $display("FAIL fp_grant%0d got=%b exp=%b", k, b_grant, 2'b01); end
            tick();
            wb_ack = 1'b1; wb_rdata = 32'h0000_1000 + k;
            #1;
            checks++; if ({a_m1_ack, a_m0_ack} !== exp_g) begin
                errors++; $display("FAIL rr_ack%0d got=%b exp=%b", k, {a_m1_ack, a_m0_ack}, exp_g); end
            checks++; if (b_m0_ack !== 1'b1 || b_m1_ack !== 1'b0) begin
                errors++; $display("FAIL fp_ack%0d got m0=%b m1=%b exp 1/0", k, b_m0_ack, b_m1_ack); end
            tick();
            wb_ack = 1'b0;
            #1;
            checks++; if (a_grant !== 2'b00 || b_grant !== 2'b00) begin
                errors++; $display("FAIL rr_bubble%0d got a=%b b=%b exp 00", k, a_grant, b_grant); end
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        m1_req = 1'b1; m1_addr = 32'h0000_0C00; m1_sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            checks++; if (a_grant !== 2'b10 || a_m1_err !== 1'b0) begin
                errors++; $display("FAIL to_gnt%0d got grant=%b err=%b exp 10/0", i, a_grant, a_m1_err); end
        end
        tick();
        #1;
        checks++; if (a_m1_err !== 1'b1 || a_m1_ack !== 1'b0) begin errors++; $display("FAIL to_err got err=%b ack=%b exp 1/0", a_m1_err, a_m1_ack); end
        checks++; if (a_m1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL to_data got=%h exp=%h", a_m1_data, 32'hDEADBEEF); end
        checks++; if (a_grant !== 2'b10 || a_wb_sel !== 4'h0 || a_wb_addr !== 32'h0 || a_m0_err !== 1'b0) begin
            errors++; $display("FAIL to_err_bus got grant=%b sel=%h addr=%h m0err=%b exp 10/0/0/0", a_grant, a_wb_sel, a_wb_addr, a_m0_err); end
        m1_req = 1'b0;
        tick();
        #1;
        checks++; if (a_grant !== 2'b00 || a_m1_err !== 1'b0) begin errors++; $display("FAIL to_idle got grant=%b err=%b exp 00/0", a_grant, a_m1_err); end
        wb_ack = 1'b1; wb_rdata = 32'h5555_AAAA;
        #1;
        checks++; if (a_m1_ack !== 1'b0 || a_m1_data !== 32'h0) begin errors++; $display("FAIL to_late_ack got ack=%b data=%h exp 0", a_m1_ack, a_m1_data); end
        tick();
        wb_ack = 1'b0;
        #1;
        checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL to_late_state got=%b exp=00", a_grant); end
    endtask

    task automatic test_abort_reset();
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h0000_0D00; m0_sel = 4'h1;
        tick();
        #1;
        checks++; if (a_grant !== 2'b01) begin errors++; $display("FAIL abort_grant got=%b exp=01", a_grant); end
        tick();
        m0_req = 1'b0;
        #1;
        checks++; if (a_m0_ack !== 1'b0) begin errors++; $display("FAIL abort_noack got=%b exp=0", a_m0_ack); end
        tick();
        #1;
        checks++; if (a_grant !== 2'b00 || a_m0_ack !== 1'b0) begin errors++; $display("FAIL abort_idle got grant=%b ack=%b exp 00/0", a_grant, a_m0_ack); end
        m1_req = 1'b1; m1_addr = 32'h0000_0E00; m1_sel = 4'h2;
        tick();
        #1;
        checks++; if (a_grant !== 2'b10) begin errors++; $display("FAIL rst_mid_grant got=%b exp=10", a_grant); end
        rst = 1'b1; wb_ack = 1'b1; wb_rdata = 32'h7777_8888;
        #1;
        checks++; if (a_grant !== 2'b00 || a_wb_addr !== 32'h0 || a_wb_sel !== 4'h0 || a_m1_ack !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs got grant=%b addr=%h sel=%h ack=%b exp 0", a_grant, a_wb_addr, a_wb_sel, a_m1_ack); end
        tick();
        rst = 1'b0; m1_req = 1'b0;
        #1;
        checks++; if (a_m1_ack !== 1'b0) begin errors++; $display("FAIL rst_release_ack got=%b exp=0", a_m1_ack); end
        tick();
        #1;
        checks++; if (a_m1_ack !== 1'b0 || a_grant !== 2'b00) begin errors++; $display("FAIL rst_after got ack=%b grant=%b exp 0/00", a_m1_ack, a_grant); end
        wb_ack = 1'b0;
    endtask

    task automatic test_ack_timeout();
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h0000_0F00; m0_sel = 4'hF;
        tick();
        tick();
        tick();
        tick();
        wb_ack = 1'b1; wb_rdata = 32'hA5A5_0F0F;
        #1;
        checks++; if (a_m0_ack !== 1'b1 || a_m0_err !== 1'b0) begin errors++; $display("FAIL sim_ack got ack=%b err=%b exp 1/0", a_m0_ack, a_m0_err); end
        checks++; if (a_m0_data !== 32'hA5A5_0F0F) begin errors++; $display("FAIL sim_data got=%h exp=%h", a_m0_data, 32'hA5A5_0F0F); end
        tick();
        wb_ack = 1'b0; m0_req = 1'b0;
        #1;
        checks++; if (a_m0_err !== 1'b0 || a_grant !== 2'b00) begin errors++; $display("FAIL sim_next got err=%b grant=%b exp 0/00", a_m0_err, a_grant); end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_ack();
        test_round_robin();
        test_timeout();
        test_abort_reset();
        test_ack_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
